vxe_mem_responder: RTL

- Memory-side responder for the VxE request/response interface. Pops requests from a request FIFO (44-bit RQA) and, for writes, a write-data FIFO (64-bit).
- Services each request from an internal word-addressed memory array.
- Pushes in-order responses into a 9-bit status FIFO (RSS) and a 64-bit data FIFO (RSD).
- Serves as the synthesizable memory end for CU fetch unit and VPU load/store paths in integration and FPGA builds.

---
 rtl/vxe_mem_if_pkg.sv | 30 +++
 rtl/vxe_mem_sp_ram.sv | 30 +++
 rtl/vxe_mem_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/vxe_mem_if_pkg.sv
// rtl/vxe_mem_if_pkg.sv - VxE memory request/response field layouts and error codes
package vxe_mem_if_pkg;

    localparam int RQA_TXN_W  = 6;
    localparam int RQA_ADDR_W = 37;
    localparam int RQA_W      = RQA_TXN_W + 1 + RQA_ADDR_W;
    localparam int RSS_ERR_W  = 2;
    localparam int RSS_W      = RQA_TXN_W + 1 + RSS_ERR_W;
    localparam int VXE_DATA_W = 64;

    typedef enum logic [RSS_ERR_W-1:0] {
        VXE_RSP_OK  = 2'b00,
        VXE_RSP_ERR = 2'b11
    } vxe_rsp_e;

    // RQA: [43:38] txnid, [37] rnw, [36:0] word address
    typedef struct packed {
        logic [RQA_TXN_W-1:0]  txnid;
        logic                  rnw;
        logic [RQA_ADDR_W-1:0] addr;
    } vxe_rqa_t;

    // RSS: [8:3] txnid, [2] rnw, [1:0] err
    typedef struct packed {
        logic [RQA_TXN_W-1:0] txnid;
        logic                 rnw;
        vxe_rsp_e             err;
    } vxe_rss_t;

endpackage

// File: rtl/vxe_mem_sp_ram.sv
// rtl/vxe_mem_sp_ram.sv - single-port synchronous RAM with read and write enables
module vxe_mem_sp_ram #(
    parameter int AW = 10,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // rdata_q only changes on an enabled read, so it holds across stalls
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/vxe_mem_responder.sv
// rtl/vxe_mem_responder.sv - three-stage in-order memory responder for the VxE request/response FIFOs
module vxe_mem_responder
    import vxe_mem_if_pkg::*;
#(
    parameter logic [RQA_ADDR_W-1:0] BASE_ADDR      = 37'h0,
    parameter int                    MEM_DEPTH_POW2 = 10
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_en,
    input  logic                  i_rqa_vld,
    input  logic [RQA_W-1:0]      i_rqa,
    output logic                  o_rqa_rd,
    input  logic                  i_rqd_vld,
    input  logic [VXE_DATA_W-1:0] i_rqd,
    output logic                  o_rqd_rd,
    input  logic                  i_rss_rdy,
    output logic [RSS_W-1:0]      o_rss,
    output logic                  o_rss_wr,
    input  logic                  i_rsd_rdy,
    output logic [VXE_DATA_W-1:0] o_rsd,
    output logic                  o_rsd_wr,
    output logic                  o_busy
);

    localparam int AW = MEM_DEPTH_POW2;

    vxe_rqa_t              rqa;
    vxe_rss_t              rss;
    logic [RQA_ADDR_W-1:0] idx;
    logic                  in_range;
    logic                  s2_drain;
    logic                  s1_free;
    logic                  accept;
    logic                  ram_en;
    logic [VXE_DATA_W-1:0] ram_rdata;

    logic                  en_q,       en_d;
    logic                  s1_vld_q,   s1_vld_d;
    logic [RQA_TXN_W-1:0]  s1_txn_q,   s1_txn_d;
    logic                  s1_rnw_q,   s1_rnw_d;
    logic [AW-1:0]         s1_idx_q,   s1_idx_d;
    logic [VXE_DATA_W-1:0] s1_wdata_q, s1_wdata_d;
    logic                  s1_inr_q,   s1_inr_d;
    logic                  s2_vld_q,   s2_vld_d;
    logic [RQA_TXN_W-1:0]  s2_txn_q,   s2_txn_d;
    logic                  s2_rnw_q,   s2_rnw_d;
    vxe_rsp_e              s2_err_q,   s2_err_d;

    always_comb begin
        rqa      = i_rqa;
        // Wrap below BASE_ADDR yields a huge index and therefore fails the range test
        idx      = rqa.addr - BASE_ADDR;
        in_range = (idx >> AW) == '0;

        s2_drain = !s2_vld_q || (i_rss_rdy && (i_rsd_rdy || !s2_rnw_q));
        s1_free  = !s1_vld_q || s2_drain;
        accept   = en_q && i_rqa_vld && s1_free && (rqa.rnw || i_rqd_vld);
        o_rqa_rd = accept;
        o_rqd_rd = accept && !rqa.rnw;

        ram_en   = s1_vld_q && s1_inr_q && s2_drain;
        en_d     = i_en;

        s1_vld_d   = s1_vld_q;
        s1_txn_d   = s1_txn_q;
        s1_rnw_d   = s1_rnw_q;
        s1_idx_d   = s1_idx_q;
        s1_wdata_d = s1_wdata_q;
        s1_inr_d   = s1_inr_q;
        if (s1_free) begin
            s1_vld_d = accept;
            if (accept) begin
                s1_txn_d   = rqa.txnid;
                s1_rnw_d   = rqa.rnw;
                s1_idx_d   = idx[AW-1:0];
                s1_wdata_d = i_rqd;
                s1_inr_d   = in_range;
            end
        end

        s2_vld_d = s2_vld_q;
        s2_txn_d = s2_txn_q;
        s2_rnw_d = s2_rnw_q;
        s2_err_d = s2_err_q;
        if (s2_drain) begin
            s2_vld_d = s1_vld_q;
            s2_txn_d = s1_txn_q;
            s2_rnw_d = s1_rnw_q;
            s2_err_d = s1_inr_q ? VXE_RSP_OK : VXE_RSP_ERR;
        end

        rss.txnid = s2_vld_q ? s2_txn_q : '0;
        rss.rnw   = s2_vld_q && s2_rnw_q;
        rss.err   = s2_vld_q ? s2_err_q : VXE_RSP_OK;
        o_rss     = rss;
        o_rss_wr  = s2_vld_q && s2_drain;
        o_rsd_wr  = s2_vld_q && s2_rnw_q && s2_drain;
        o_rsd     = (s2_vld_q && s2_rnw_q && s2_err_q == VXE_RSP_OK) ? ram_rdata : '0;
        o_busy    = s1_vld_q || s2_vld_q;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            en_q       <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_txn_q   <= '0;
            s1_rnw_q   <= 1'b0;
            s1_idx_q   <= '0;
            s1_wdata_q <= '0;
            s1_inr_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_txn_q   <= '0;
            s2_rnw_q   <= 1'b0;
            s2_err_q   <= VXE_RSP_OK;
        end else begin
            en_q       <= en_d;
            s1_vld_q   <= s1_vld_d;
            s1_txn_q   <= s1_txn_d;
            s1_rnw_q   <= s1_rnw_d;
            s1_idx_q   <= s1_idx_d;
            s1_wdata_q <= s1_wdata_d;
            s1_inr_q   <= s1_inr_d;
            s2_vld_q   <= s2_vld_d;
            s2_txn_q   <= s2_txn_d;
            s2_rnw_q   <= s2_rnw_d;
            s2_err_q   <= s2_err_d;
        end
    end

    vxe_mem_sp_ram #(
        .AW (AW),
        .DW (VXE_DATA_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (!s1_rnw_q),
        .addr  (s1_idx_q),
        .wdata (s1_wdata_q),
        .rdata (ram_rdata)
    );

endmodule
